// File: rtl/ddr3_mcb_dat_path_if.sv
// rtl/ddr3_mcb_dat_path_if.sv - user, data-control, PHY and status signals of the MCB data path
interface ddr3_mcb_dat_path_if #(
    parameter int DQ_W   = 16,
    parameter int DM_W   = 2,
    parameter int WFF_AW = 2
);
    logic                ddr3_mcb_wdat_req;
    logic [2*DQ_W-1:0]   ddr3_mcb_wdat;
    logic [2*DM_W-1:0]   ddr3_mcb_wdm;
    logic [2*DQ_W-1:0]   ddr3_mcb_rdat;
    logic                ddr3_mcb_rdat_vld;
    logic                d_wr_ld;
    logic                d_dp_oe;
    logic                d_dp_ie;
    logic [DQ_W-1:0]     phy_dq_o_r;
    logic [DQ_W-1:0]     phy_dq_o_f;
    logic [DM_W-1:0]     phy_dm_o_r;
    logic [DM_W-1:0]     phy_dm_o_f;
    logic                phy_dq_oe;
    logic                phy_dqs_oe;
    logic [DQ_W-1:0]     phy_dq_i_r;
    logic [DQ_W-1:0]     phy_dq_i_f;
    logic [WFF_AW:0]     wff_cnt;
    logic                wff_ovf;
    logic                wff_udf;

    modport slave (
        input  ddr3_mcb_wdat_req, ddr3_mcb_wdat, ddr3_mcb_wdm,
        input  d_wr_ld, d_dp_oe, d_dp_ie, phy_dq_i_r, phy_dq_i_f,
        output ddr3_mcb_rdat, ddr3_mcb_rdat_vld,
        output phy_dq_o_r, phy_dq_o_f, phy_dm_o_r, phy_dm_o_f, phy_dq_oe, phy_dqs_oe,
        output wff_cnt, wff_ovf, wff_udf
    );

    modport master (
        output ddr3_mcb_wdat_req, ddr3_mcb_wdat, ddr3_mcb_wdm,
        output d_wr_ld, d_dp_oe, d_dp_ie, phy_dq_i_r, phy_dq_i_f,
        input  ddr3_mcb_rdat, ddr3_mcb_rdat_vld,
        input  phy_dq_o_r, phy_dq_o_f, phy_dm_o_r, phy_dm_o_f, phy_dq_oe, phy_dqs_oe,
        input  wff_cnt, wff_ovf, wff_udf
    );
endinterface

// File: rtl/ddr3_mcb_dat_path.sv
// rtl/ddr3_mcb_dat_path.sv - MCB data path: write FIFO to PHY beat registers, PHY read capture
module ddr3_mcb_dat_path #(
    parameter int DQ_W      = 16,
    parameter int DM_W      = 2,
    parameter int WFF_DEPTH = 4,
    parameter int WFF_AW    = 2
) (
    input  logic ddr3_mcb_clk,
    input  logic ddr3_mcb_rst_n,
    ddr3_mcb_dat_path_if.slave bus
);
    localparam int WW = 2*DQ_W + 2*DM_W;

    // Each entry is {wdm, wdat}; the low half of each field is the rise beat
    logic [WW-1:0]     mem [WFF_DEPTH];
    logic [WFF_AW-1:0] rd_ptr;
    logic [WFF_AW-1:0] wr_ptr;
    logic [WFF_AW:0]   cnt;
    logic              push_en;
    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;
    logic [WW-1:0]     head;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (WFF_AW+1)'(WFF_DEPTH));
    assign do_pop  = bus.d_wr_ld && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_push = push_en && (!full || do_pop);
    assign head    = mem[rd_ptr];

    assign bus.wff_cnt    = cnt;
    assign bus.phy_dq_oe  = bus.d_dp_oe;
    assign bus.phy_dqs_oe = bus.d_dp_oe | bus.d_wr_ld;

    always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
        if (!ddr3_mcb_rst_n) begin
            for (int i = 0; i < WFF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr                <= '0;
            wr_ptr                <= '0;
            cnt                   <= '0;
            push_en               <= 1'b0;
            bus.phy_dq_o_r        <= '0;
            bus.phy_dq_o_f        <= '0;
            bus.phy_dm_o_r        <= '0;
            bus.phy_dm_o_f        <= '0;
            bus.wff_ovf           <= 1'b0;
            bus.wff_udf           <= 1'b0;
            bus.ddr3_mcb_rdat     <= '0;
            bus.ddr3_mcb_rdat_vld <= 1'b0;
        end else begin
            push_en <= bus.ddr3_mcb_wdat_req;

            if (do_push) begin
                mem[wr_ptr] <= {bus.ddr3_mcb_wdm, bus.ddr3_mcb_wdat};
                wr_ptr      <= wr_ptr + WFF_AW'(1);
            end
            if (push_en && full && !do_pop) begin
                bus.wff_ovf <= 1'b1;
            end

            if (bus.d_wr_ld) begin
                if (!empty) begin
                    bus.phy_dq_o_r <= head[DQ_W-1:0];
                    bus.phy_dq_o_f <= head[2*DQ_W-1:DQ_W];
                    bus.phy_dm_o_r <= head[2*DQ_W+DM_W-1:2*DQ_W];
                    bus.phy_dm_o_f <= head[WW-1:2*DQ_W+DM_W];
                    rd_ptr         <= rd_ptr + WFF_AW'(1);
                end else begin
                    // Underflow: drive a fully masked beat so the DRAM ignores it
                    bus.wff_udf    <= 1'b1;
                    bus.phy_dq_o_r <= '0;
                    bus.phy_dq_o_f <= '0;
                    bus.phy_dm_o_r <= '1;
                    bus.phy_dm_o_f <= '1;
                end
            end

            cnt <= cnt + (WFF_AW+1)'(do_push) - (WFF_AW+1)'(do_pop);

            if (bus.d_dp_ie) begin
                bus.ddr3_mcb_rdat <= {bus.phy_dq_i_f, bus.phy_dq_i_r};
            end
            bus.ddr3_mcb_rdat_vld <= bus.d_dp_ie;
        end
    end
endmodule

// File: tb/tb_ddr3_mcb_dat_path.sv
// tb/tb_ddr3_mcb_dat_path.sv - self-checking bench for ddr3_mcb_dat_path
module tb_ddr3_mcb_dat_path;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    ddr3_mcb_dat_path_if #(.DQ_W(16), .DM_W(2), .WFF_AW(2)) bus ();

    ddr3_mcb_dat_path #(.DQ_W(16), .DM_W(2), .WFF_DEPTH(4), .WFF_AW(2)) dut (
        .ddr3_mcb_clk   (clk),
        .ddr3_mcb_rst_n (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          req, ld, oe, ie;
        logic [31:0] wdat;
        logic [3:0]  wdm;
        logic [15:0] ir, ifl;
    } cyc_in_t;

    typedef struct {
        cyc_in_t     in;
        logic [15:0] dqr, dqf;
        logic [2:0]  cnt;
        logic [31:0] rdat;
        bit          rvld;
    } vec_t;

    // Reference model: a plain queue of {wdm, wdat} words
    logic [35:0] m_q[$];
    bit          m_push_pend;
    logic [15:0] m_dqr, m_dqf;
    logic [1:0]  m_dmr, m_dmf;
    bit          m_ovf, m_udf, m_rvld;
    logic [31:0] m_rdat;
    logic [31:0] words[5];

    function automatic cyc_in_t mk_in(bit req, bit ld, bit oe, bit ie, logic [31:0] wdat,
                                      logic [3:0] wdm, logic [15:0] ir, logic [15:0] ifl);
        cyc_in_t c;
        c.req = req; c.ld = ld; c.oe = oe; c.ie = ie;
        c.wdat = wdat; c.wdm = wdm; c.ir = ir; c.ifl = ifl;
        return c;
    endfunction

    function automatic vec_t mk_v(cyc_in_t in, logic [15:0] dqr, logic [15:0] dqf,
                                  logic [2:0] cnt, logic [31:0] rdat, bit rvld);
        vec_t v;
        v.in = in; v.dqr = dqr; v.dqf = dqf; v.cnt = cnt; v.rdat = rdat; v.rvld = rvld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_push_pend = 0;
        m_dqr = '0; m_dqf = '0; m_dmr = '0; m_dmf = '0;
        m_ovf = 0; m_udf = 0; m_rvld = 0; m_rdat = '0;
    endtask

    task automatic m_step(input cyc_in_t c);
        logic [35:0] w;
        if (c.ld) begin
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                m_dqr = w[15:0]; m_dqf = w[31:16]; m_dmr = w[33:32]; m_dmf = w[35:34];
            end else begin
                m_udf = 1; m_dqr = '0; m_dqf = '0; m_dmr = 2'b11; m_dmf = 2'b11;
            end
        end
        if (m_push_pend) begin
            if (m_q.size() < 4) m_q.push_back({c.wdm, c.wdat});
            else m_ovf = 1;
        end
        m_push_pend = c.req;
        if (c.ie) m_rdat = {c.ifl, c.ir};
        m_rvld = c.ie;
    endtask

    task automatic drive(input cyc_in_t c);
        bus.ddr3_mcb_wdat_req = c.req;
        bus.d_wr_ld           = c.ld;
        bus.d_dp_oe           = c.oe;
        bus.d_dp_ie           = c.ie;
        bus.ddr3_mcb_wdat     = c.wdat;
        bus.ddr3_mcb_wdm      = c.wdm;
        bus.phy_dq_i_r        = c.ir;
        bus.phy_dq_i_f        = c.ifl;
    endtask

    // Entered and left at posedge+1
    task automatic run_cycle(input cyc_in_t c);
        drive(c);
        #3;
        chk("phy_dq_oe", 64'(bus.phy_dq_oe), 64'(c.oe));
        chk("phy_dqs_oe", 64'(bus.phy_dqs_oe), 64'(c.oe | c.ld));
        m_step(c);
        @(posedge clk);
        #1;
        chk("phy_dq_o_r", 64'(bus.phy_dq_o_r), 64'(m_dqr));
        chk("phy_dq_o_f", 64'(bus.phy_dq_o_f), 64'(m_dqf));
        chk("phy_dm_o_r", 64'(bus.phy_dm_o_r), 64'(m_dmr));
        chk("phy_dm_o_f", 64'(bus.phy_dm_o_f), 64'(m_dmf));
        chk("wff_cnt", 64'(bus.wff_cnt), 64'(m_q.size()));
        chk("wff_ovf", 64'(bus.wff_ovf), 64'(m_ovf));
        chk("wff_udf", 64'(bus.wff_udf), 64'(m_udf));
        chk("rdat", 64'(bus.ddr3_mcb_rdat), 64'(m_rdat));
        chk("rdat_vld", 64'(bus.ddr3_mcb_rdat_vld), 64'(m_rvld));
    endtask

    task automatic do_reset();
        drive(mk_in(0, 0, 0, 0, '0, '0, '0, '0));
        rst_n = 1'b0;
        m_reset();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Word i is driven one cycle after its request
    task automatic push_n(input int n);
        for (int i = 0; i <= n; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i > 0) words[i-1] = d;
            run_cycle(mk_in(i < n, 0, 0, 0, d, 4'($urandom), '0, '0));
        end
    endtask

    task automatic ld_burst(input int n);
        for (int i = 0; i <= n; i++) begin
            run_cycle(mk_in(0, i < n, i > 0, 0, $urandom, '0, '0, '0));
        end
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = mk_v(mk_in(1, 0, 0, 0, 32'h0,        0, 0, 0), 16'h0000, 16'h0000, 0, 32'h0, 0);
        tbl[1]  = mk_v(mk_in(1, 0, 0, 0, 32'h11110000, 0, 0, 0), 16'h0000, 16'h0000, 1, 32'h0, 0);
        tbl[2]  = mk_v(mk_in(1, 0, 0, 0, 32'h33332222, 0, 0, 0), 16'h0000, 16'h0000, 2, 32'h0, 0);
        tbl[3]  = mk_v(mk_in(1, 0, 0, 0, 32'h55554444, 0, 0, 0), 16'h0000, 16'h0000, 3, 32'h0, 0);
        tbl[4]  = mk_v(mk_in(0, 0, 0, 0, 32'h77776666, 0, 0, 0), 16'h0000, 16'h0000, 4, 32'h0, 0);
        tbl[5]  = mk_v(mk_in(0, 1, 0, 0, 32'h0,        0, 0, 0), 16'h0000, 16'h1111, 3, 32'h0, 0);
        tbl[6]  = mk_v(mk_in(0, 1, 1, 0, 32'h0,        0, 0, 0), 16'h2222, 16'h3333, 2, 32'h0, 0);
        tbl[7]  = mk_v(mk_in(0, 1, 1, 0, 32'h0,        0, 0, 0), 16'h4444, 16'h5555, 1, 32'h0, 0);
        tbl[8]  = mk_v(mk_in(0, 1, 1, 0, 32'h0,        0, 0, 0), 16'h6666, 16'h7777, 0, 32'h0, 0);
        tbl[9]  = mk_v(mk_in(0, 0, 1, 0, 32'h0,        0, 0, 0), 16'h6666, 16'h7777, 0, 32'h0, 0);
        tbl[10] = mk_v(mk_in(0, 0, 0, 0, 32'h0,        0, 0, 0), 16'h6666, 16'h7777, 0, 32'h0, 0);
        tbl[11] = mk_v(mk_in(0, 0, 0, 1, 32'h0, 0, 16'h00A0, 16'h00B0), 16'h6666, 16'h7777, 0, 32'h00B000A0, 1);
        tbl[12] = mk_v(mk_in(0, 0, 0, 1, 32'h0, 0, 16'h00A1, 16'h00B1), 16'h6666, 16'h7777, 0, 32'h00B100A1, 1);
        tbl[13] = mk_v(mk_in(0, 0, 0, 1, 32'h0, 0, 16'h00A2, 16'h00B2), 16'h6666, 16'h7777, 0, 32'h00B200A2, 1);
        tbl[14] = mk_v(mk_in(0, 0, 0, 1, 32'h0, 0, 16'h00A3, 16'h00B3), 16'h6666, 16'h7777, 0, 32'h00B300A3, 1);
        tbl[15] = mk_v(mk_in(0, 0, 0, 0, 32'h0, 0, 16'hFFFF, 16'hFFFF), 16'h6666, 16'h7777, 0, 32'h00B300A3, 0);

        rst_n = 1'b0;
        drive(mk_in(0, 0, 0, 0, '0, '0, '0, '0));
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dq_o_r", 64'(bus.phy_dq_o_r), 64'h0);
        chk("rst_dm_o_f", 64'(bus.phy_dm_o_f), 64'h0);
        chk("rst_cnt", 64'(bus.wff_cnt), 64'h0);
        chk("rst_ovf", 64'(bus.wff_ovf), 64'h0);
        chk("rst_udf", 64'(bus.wff_udf), 64'h0);
        chk("rst_rdat", 64'(bus.ddr3_mcb_rdat), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_cycle(tbl[i].in);
            chk($sformatf("tbl%0d_dq_r", i), 64'(bus.phy_dq_o_r), 64'(tbl[i].dqr));
            chk($sformatf("tbl%0d_dq_f", i), 64'(bus.phy_dq_o_f), 64'(tbl[i].dqf));
            chk($sformatf("tbl%0d_dm", i), 64'({bus.phy_dm_o_f, bus.phy_dm_o_r}), 64'h0);
            chk($sformatf("tbl%0d_cnt", i), 64'(bus.wff_cnt), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_err", i), 64'({bus.wff_ovf, bus.wff_udf}), 64'h0);
            chk($sformatf("tbl%0d_rdat", i), 64'(bus.ddr3_mcb_rdat), 64'(tbl[i].rdat));
            chk($sformatf("tbl%0d_rvld", i), 64'(bus.ddr3_mcb_rdat_vld), 64'(tbl[i].rvld));
        end

        // FIFO full: fifth word dropped, later burst yields the first four
        do_reset();
        push_n(5);
        chk("full_cnt", 64'(bus.wff_cnt), 64'd4);
        chk("full_ovf", 64'(bus.wff_ovf), 64'd1);
        ld_burst(4);
        chk("full_last_dq_r", 64'(bus.phy_dq_o_r), 64'(words[3][15:0]));
        chk("full_last_dq_f", 64'(bus.phy_dq_o_f), 64'(words[3][31:16]));
        chk("full_drained", 64'(bus.wff_cnt), 64'd0);

        // Underflow: masked zero beat
        run_cycle(mk_in(0, 1, 0, 0, '0, '0, '0, '0));
        chk("udf_flag", 64'(bus.wff_udf), 64'd1);
        chk("udf_dq", 64'({bus.phy_dq_o_f, bus.phy_dq_o_r}), 64'h0);
        chk("udf_dm", 64'({bus.phy_dm_o_f, bus.phy_dm_o_r}), 64'hF);

        // Simultaneous push and pop at count 2, then wrap over three bursts
        do_reset();
        push_n(2);
        run_cycle(mk_in(1, 0, 0, 0, $urandom, '0, '0, '0));
        run_cycle(mk_in(0, 1, 0, 0, $urandom, 4'($urandom), '0, '0));
        chk("pp_cnt", 64'(bus.wff_cnt), 64'd2);
        ld_burst(2);
        for (int b = 0; b < 3; b++) begin
            push_n(4);
            ld_burst(4);
        end
        chk("wrap_flags", 64'({bus.wff_ovf, bus.wff_udf}), 64'h0);

        // Reset mid-burst with three words queued
        push_n(4);
        run_cycle(mk_in(0, 1, 0, 0, '0, '0, '0, '0));
        chk("mid_cnt3", 64'(bus.wff_cnt), 64'd3);
        drive(mk_in(0, 0, 0, 0, '0, '0, '0, '0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dq", 64'({bus.phy_dq_o_f, bus.phy_dq_o_r}), 64'h0);
        chk("mid_rst_dm", 64'({bus.phy_dm_o_f, bus.phy_dm_o_r}), 64'h0);
        chk("mid_rst_cnt", 64'(bus.wff_cnt), 64'h0);
        chk("mid_rst_oe", 64'({bus.phy_dq_oe, bus.phy_dqs_oe}), 64'h0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_n(4);
        ld_burst(4);
        chk("post_rst_flags", 64'({bus.wff_ovf, bus.wff_udf}), 64'h0);

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            run_cycle(mk_in($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                            $urandom_range(0, 1), $urandom, 4'($urandom), 16'($urandom), 16'($urandom)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
